alu_ctrl: RTL

Sequencer that drives the datapath ALU from the control side. It accepts one ALU instruction at a time over a valid/ready handshake and reads two operands from an internal 4x8 register file. It presents the operands and mode to the ALU as registered signals, captures the result and carry/zero, then writes back the result and updates the architectural flags. It sits between the instruction decoder and the combinational ALU in the 8-bit microprocessor.

---
 rtl/alu_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// Control sequencer for the combinational ALU: accepts one instruction, issues
// registered operands, captures the result and retires it into a 4x8 register file.
module alu_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              done,
  output logic              illegal,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITE} state_t;

  localparam logic [2:0] M_ADD = 3'b000;
  localparam logic [2:0] M_SUB = 3'b001;
  localparam logic [2:0] M_CMP = 3'b010;

  state_t state, state_next;

  logic [DATA_W-1:0] regs [NREGS];
  logic [2:0]        mode_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rs_q;
  logic [DATA_W-1:0] res_q;
  logic              res_zero;
  logic              res_carry;
  logic              mode_illegal;
  logic              instr_unused;

  assign instr_unused = instr[4];
  assign mode_illegal = mode_q[2] & mode_q[1];
  assign dbg_data     = regs[dbg_addr];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: an instruction transfers when instr_valid && instr_ready at a
  // rising edge; instr_ready is only offered in IDLE and yields to a load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!ld_en && instr_valid) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    instr_ready = 1'b0;
    if (state == IDLE) instr_ready = !ld_en;
  end

  // Datapath: register file, latched fields, ALU drive, capture and retire
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      mode_q     <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_mode   <= '0;
      res_q      <= '0;
      res_zero   <= 1'b0;
      res_carry  <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end else if (instr_valid) begin
            mode_q <= instr[7:5];
            rd_q   <= instr[3:2];
            rs_q   <= instr[1:0];
          end
        end
        ISSUE: begin
          alu_in1  <= regs[rs_q];
          alu_in2  <= regs[rd_q];
          alu_mode <= mode_q;
        end
        CAPTURE: begin
          res_q <= alu_out;
          // Only CMP trusts the ALU's zero output; other modes test the result here.
          case (mode_q)
            M_ADD, M_SUB: begin
              res_zero  <= (alu_out == '0);
              res_carry <= alu_carry;
            end
            M_CMP: begin
              res_zero  <= alu_zero;
              res_carry <= alu_carry;
            end
            default: begin
              res_zero  <= (alu_out == '0);
              res_carry <= 1'b0;
            end
          endcase
        end
        WRITE: begin
          done <= 1'b1;
          if (mode_illegal) begin
            illegal <= 1'b1;
          end else begin
            if (mode_q != M_CMP) regs[rd_q] <= res_q;
            flag_zero  <= res_zero;
            flag_carry <= res_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
